// File: rtl/snd_voice_mixer.sv
// Polyphonic sample player: up to NB_VOICES voices read a shared sample ROM and
// are summed with saturation into one signed DAC sample per data_ena strobe.
module snd_voice_mixer #(
  parameter int unsigned NB_VOICES = 4,
  parameter int unsigned NB_SOUNDS = 4,
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned SAMPLE_W  = 8,
  parameter int unsigned OUT_W     = 16
) (
  input  logic                          clk_50,
  input  logic                          reset_n,
  input  logic [NB_SOUNDS-1:0]          trig,
  input  logic [NB_SOUNDS-1:0]          loop_en,
  input  logic                          stop_all,
  input  logic [NB_SOUNDS*ADDR_W-1:0]   snd_start,
  input  logic [NB_SOUNDS*ADDR_W-1:0]   snd_end,
  input  logic                          data_ena,
  output logic [ADDR_W-1:0]             rom_addr,
  input  logic [SAMPLE_W-1:0]           rom_data,
  output logic [OUT_W-1:0]              dac_data,
  output logic                          dac_valid,
  output logic [NB_VOICES-1:0]          voice_busy,
  output logic                          drop,
  output logic                          overrun
);

  localparam int unsigned VID_W  = (NB_VOICES > 1) ? $clog2(NB_VOICES) : 1;
  localparam int unsigned SID_W  = (NB_SOUNDS > 1) ? $clog2(NB_SOUNDS) : 1;
  localparam int unsigned CNT_W  = $clog2(NB_VOICES + 2) + 1;
  localparam int unsigned SH     = OUT_W - SAMPLE_W;
  localparam int unsigned ACC_W  = SAMPLE_W + $clog2(NB_VOICES) + 1;
  localparam int unsigned WIDE_W = ACC_W + SH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_VOICES + 1);
  localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [WIDE_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_OUT   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]         cnt;
  logic signed [ACC_W-1:0]  acc;
  logic [NB_VOICES-1:0]     active;
  logic [ADDR_W-1:0]        addr [NB_VOICES];
  logic [SID_W-1:0]         sid  [NB_VOICES];
  logic [NB_SOUNDS-1:0]     pending, pend_nxt;

  logic                     alloc_any, alloc_en, hit_any, free_any;
  logic [SID_W-1:0]         alloc_k;
  logic [VID_W-1:0]         hit_v, free_v;
  logic [ADDR_W-1:0]        alloc_start;

  logic                     fetch_en, acc_vld, acc_live;
  logic [VID_W-1:0]         fetch_v, acc_v;
  logic signed [ACC_W-1:0]  contrib, mix_sum;
  logic signed [WIDE_W-1:0] wide;
  logic [OUT_W-1:0]         sat;
  logic [SID_W-1:0]         cur_sid;
  logic [ADDR_W-1:0]        cur_addr, cur_start, cur_end;
  logic                     cur_loop;

  assign voice_busy = active;

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (data_ena) state_nxt = S_FETCH;
      S_FETCH: if (cnt == LAST_CNT) state_nxt = S_OUT;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lowest pending sound; retrigger its voice if already playing, else lowest free voice.
  always_comb begin
    alloc_any = 1'b0;
    alloc_k   = '0;
    for (int unsigned k = NB_SOUNDS; k > 0; k--) begin
      if (pending[k-1]) begin
        alloc_any = 1'b1;
        alloc_k   = SID_W'(k - 1);
      end
    end
    hit_any  = 1'b0;
    hit_v    = '0;
    free_any = 1'b0;
    free_v   = '0;
    for (int unsigned v = NB_VOICES; v > 0; v--) begin
      if (active[v-1] && sid[v-1] == alloc_k) begin
        hit_any = 1'b1;
        hit_v   = VID_W'(v - 1);
      end
      if (!active[v-1]) begin
        free_any = 1'b1;
        free_v   = VID_W'(v - 1);
      end
    end
    alloc_en    = (state == S_IDLE) && !data_ena && alloc_any;
    alloc_start = snd_start[int'(alloc_k)*ADDR_W +: ADDR_W];
    pend_nxt    = pending;
    if (alloc_en) pend_nxt[alloc_k] = 1'b0;
    pend_nxt = pend_nxt | trig;
    if (stop_all) pend_nxt = '0;
  end

  // ROM data lags rom_addr by one cycle: voice c-1 is fetched while voice c-2 is summed.
  always_comb begin
    fetch_en = (state == S_IDLE) && data_ena;
    fetch_v  = '0;
    acc_vld  = 1'b0;
    acc_v    = '0;
    for (int unsigned v = 0; v < NB_VOICES; v++) begin
      if (state == S_FETCH && cnt == CNT_W'(v + 2)) begin
        acc_vld = 1'b1;
        acc_v   = VID_W'(v);
      end
    end
    for (int unsigned v = 1; v < NB_VOICES; v++) begin
      if (state == S_FETCH && cnt == CNT_W'(v)) begin
        fetch_en = 1'b1;
        fetch_v  = VID_W'(v);
      end
    end
    acc_live = acc_vld && active[acc_v];
    if (acc_live) contrib = ACC_W'(signed'(rom_data));
    else          contrib = '0;
    mix_sum = acc + contrib;
    wide    = WIDE_W'(mix_sum) <<< SH;
    if (wide > SAT_MAX)      sat = SAT_MAX[OUT_W-1:0];
    else if (wide < SAT_MIN) sat = SAT_MIN[OUT_W-1:0];
    else                     sat = wide[OUT_W-1:0];
    cur_sid   = sid[acc_v];
    cur_addr  = addr[acc_v];
    cur_start = snd_start[int'(cur_sid)*ADDR_W +: ADDR_W];
    cur_end   = snd_end[int'(cur_sid)*ADDR_W +: ADDR_W];
    cur_loop  = loop_en[cur_sid];
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      acc       <= '0;
      rom_addr  <= '0;
      dac_data  <= '0;
      dac_valid <= 1'b0;
      drop      <= 1'b0;
      overrun   <= 1'b0;
      pending   <= '0;
      active    <= '0;
      for (int unsigned v = 0; v < NB_VOICES; v++) begin
        addr[v] <= '0;
        sid[v]  <= '0;
      end
    end else begin
      pending   <= pend_nxt;
      dac_valid <= 1'b0;
      drop      <= 1'b0;
      overrun   <= data_ena && (state != S_IDLE);
      if (state == S_IDLE && data_ena) begin
        acc <= '0;
        cnt <= CNT_W'(1);
      end else if (state == S_FETCH) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (fetch_en) rom_addr <= addr[fetch_v];
      if (acc_vld) acc <= mix_sum;
      if (state == S_FETCH && cnt == LAST_CNT) begin
        dac_data  <= sat;
        dac_valid <= 1'b1;
      end
      if (alloc_en) begin
        if (hit_any) begin
          addr[hit_v] <= alloc_start;
        end else if (free_any) begin
          active[free_v] <= 1'b1;
          sid[free_v]    <= alloc_k;
          addr[free_v]   <= alloc_start;
        end else begin
          drop <= 1'b1;
        end
      end
      if (acc_live) begin
        if (cur_addr != cur_end) addr[acc_v]   <= cur_addr + ADDR_W'(1);
        else if (cur_loop)       addr[acc_v]   <= cur_start;
        else                     active[acc_v] <= 1'b0;
      end
      if (stop_all) active <= '0;
    end
  end

endmodule
